axi_lite_regfile: RTL
=====================

AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

Interface
REQ-001 Parameter DATA_W, default 8, data width in bits (multiple of 4, 4..32).
REQ-002 Parameter ADDR_W, default 4, address width in bits.
REQ-003 Parameter DEPTH, default 16, number of implemented entries, DEPTH <= 2**ADDR_W.
REQ-004 Parameter NUM_DIGITS, default 2, seven-segment digits driven, NUM_DIGITS <= DATA_W/4.
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 s_awvalid in 1 / s_awready out 1 / s_awaddr in ADDR_W  write-address channel.
REQ-008 s_wvalid in 1 / s_wready out 1 / s_wdata in DATA_W  write-data channel.
REQ-009 s_bvalid out 1 / s_bready in 1 / s_bresp out 2  write-response channel.
REQ-010 s_arvalid in 1 / s_arready out 1 / s_araddr in ADDR_W  read-address channel.
REQ-011 s_rvalid out 1 / s_rready in 1 / s_rdata out DATA_W / s_rresp out 2  read-data channel.
REQ-012 disp_seg  out  8*NUM_DIGITS  active-low segments {a,b,c,d,e,f,g,dp} per digit, bit 7 = a, digit k at bits [8k+7:8k].

Function
REQ-013 A transfer on any channel SHALL occur only on a cycle where valid and ready are both 1.
REQ-014 Write FSM SHALL have states W_IDLE and W_RESP.
REQ-015 In W_IDLE, s_awready SHALL be 1 until an address is captured and s_wready 1 until data is captured; AW and W may arrive in either order or the same cycle.
REQ-016 On the cycle both address and data are held, the write SHALL commit and the FSM SHALL enter W_RESP next cycle with s_bvalid=1, s_awready=s_wready=0.
REQ-017 s_bresp SHALL be 2'b00 (OKAY) for address < DEPTH; otherwise 2'b10 (SLVERR), memory unchanged.
REQ-018 W_RESP SHALL hold s_bvalid and s_bresp stable until s_bready=1, then return to W_IDLE next cycle.
REQ-019 Read FSM SHALL have states R_IDLE (s_arready=1) and R_DATA (s_arready=0, s_rvalid=1).
REQ-020 On AR handshake, s_rdata SHALL be registered from mem[s_araddr] and R_DATA entered next cycle (1-cycle latency); s_rresp=00 for address < DEPTH, else 10 with s_rdata=0.
REQ-021 R_DATA SHALL hold s_rdata/s_rresp stable until s_rready=1, then return to R_IDLE next cycle.
REQ-022 Read and write FSMs SHALL operate concurrently and independently.
REQ-023 AR handshake on the same cycle a write commits to the same address SHALL return the pre-write value.
REQ-024 On each R handshake with s_rresp=00, disp_seg digit k SHALL update next cycle to the hex encoding of s_rdata[4k+3:4k]; SLVERR reads SHALL leave disp_seg unchanged.
REQ-025 Encoding 0..F: 03,9F,25,0D,99,49,41,1F,01,09,11,C1,63,85,61,71 (hex).
REQ-026 s_rvalid, s_bvalid, disp_seg SHALL be registered outputs; no combinational valid-to-ready path.

Reset
REQ-027 While reset=1 at a clock edge: both FSMs to idle, s_bvalid=s_rvalid=0, s_bresp=s_rresp=00, s_rdata=0, captured AW/W flags cleared.
REQ-028 Reset SHALL set mem[i]=i truncated to DATA_W for all i < DEPTH.
REQ-029 Reset SHALL set every digit of disp_seg to 8'h03.
REQ-030 Reset mid-transaction SHALL abandon the transaction with no memory write and no response.
REQ-031 s_awready, s_wready, s_arready SHALL be 1 on the first cycle after reset deasserts.

Verification
REQ-032 After reset, read address 5, rready=1 -> s_rvalid one cycle after AR handshake, s_rdata=0x05, rresp=00, disp_seg=16'h0349.
REQ-033 W one cycle before AW, addr 3, data 0xA7, bready held 0 for 3 cycles -> bvalid held stable, bresp=00; read addr 3 returns 0xA7, disp_seg=16'h111F.
REQ-034 DEPTH=12, write addr 14 -> bresp=10, no memory change; read addr 14 -> rresp=10, rdata=0, disp_seg unchanged.
REQ-035 Same-cycle AR and write commit to addr 2 (data 0x5C) -> rdata=0x02; next read returns 0x5C.
REQ-036 Reset asserted while s_rvalid=1 and AW captured without W -> after reset, s_rvalid=0, all readies 1, mem unchanged from reset values.

Source files
------------

// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite slave bus bundle for the register file.
// Five channels grouped; master drives requests, slave drives responses.
interface axi_lite_regfile_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              s_awvalid;
    logic              s_awready;
    logic [ADDR_W-1:0] s_awaddr;
    logic              s_wvalid;
    logic              s_wready;
    logic [DATA_W-1:0] s_wdata;
    logic              s_bvalid;
    logic              s_bready;
    logic [1:0]        s_bresp;
    logic              s_arvalid;
    logic              s_arready;
    logic [ADDR_W-1:0] s_araddr;
    logic              s_rvalid;
    logic              s_rready;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;

    modport master (
        output s_awvalid, s_awaddr,
        output s_wvalid, s_wdata,
        output s_bready,
        output s_arvalid, s_araddr,
        output s_rready,
        input  s_awready, s_wready,
        input  s_bvalid, s_bresp,
        input  s_arready,
        input  s_rvalid, s_rdata, s_rresp
    );

    modport slave (
        input  s_awvalid, s_awaddr,
        input  s_wvalid, s_wdata,
        input  s_bready,
        input  s_arvalid, s_araddr,
        input  s_rready,
        output s_awready, s_wready,
        output s_bvalid, s_bresp,
        output s_arready,
        output s_rvalid, s_rdata, s_rresp
    );
endinterface

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register file with independent read/write FSMs.
// Last good read is shown in hex on active-low seven-segment digits.
module axi_lite_regfile #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int DEPTH      = 16,
    parameter int NUM_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    axi_lite_regfile_if.slave       bus,
    output logic [8*NUM_DIGITS-1:0] disp_seg
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    function automatic logic [7:0] seg7(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'h03;
            4'h1: s = 8'h9F;
            4'h2: s = 8'h25;
            4'h3: s = 8'h0D;
            4'h4: s = 8'h99;
            4'h5: s = 8'h49;
            4'h6: s = 8'h41;
            4'h7: s = 8'h1F;
            4'h8: s = 8'h01;
            4'h9: s = 8'h09;
            4'hA: s = 8'h11;
            4'hB: s = 8'hC1;
            4'hC: s = 8'h63;
            4'hD: s = 8'h85;
            4'hE: s = 8'h61;
            default: s = 8'h71;
        endcase
        return s;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    // ---------------- write path ----------------
    w_state_t          w_state;
    w_state_t          w_next;
    logic              aw_held;
    logic              w_held;
    logic [ADDR_W-1:0] aw_addr;
    logic [DATA_W-1:0] w_data;
    logic [1:0]        bresp_q;
    logic              aw_fire;
    logic              w_fire;
    logic              commit;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ok;

    // Readies depend only on registered state, never on valids.
    assign bus.s_awready = (w_state == W_IDLE) && !aw_held;
    assign bus.s_wready  = (w_state == W_IDLE) && !w_held;
    assign bus.s_bresp   = bresp_q;

    assign aw_fire = bus.s_awvalid && bus.s_awready;
    assign w_fire  = bus.s_wvalid && bus.s_wready;
    assign commit  = (w_state == W_IDLE)
                   && (aw_held || aw_fire)
                   && (w_held || w_fire);

    assign wr_addr = aw_held ? aw_addr : bus.s_awaddr;
    assign wr_data = w_held ? w_data : bus.s_wdata;
    assign wr_ok   = {1'b0, wr_addr} < DEPTH_L;

    always_comb begin
        w_next       = w_state;
        bus.s_bvalid = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if (commit) w_next = W_RESP;
            end
            W_RESP: begin
                bus.s_bvalid = 1'b1;
                if (bus.s_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state <= W_IDLE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            w_state <= w_next;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_fire) begin
                    aw_held <= 1'b1;
                    aw_addr <= bus.s_awaddr;
                end
                if (w_fire) begin
                    w_held <= 1'b1;
                    w_data <= bus.s_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= DATA_W'(i);
        end else if (commit && wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // ---------------- read path ----------------
    r_state_t          r_state;
    r_state_t          r_next;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic              ar_fire;
    logic              r_fire;
    logic              rd_ok;

    assign bus.s_arready = (r_state == R_IDLE);
    assign bus.s_rdata   = rdata_q;
    assign bus.s_rresp   = rresp_q;

    assign ar_fire = bus.s_arvalid && bus.s_arready;
    assign r_fire  = bus.s_rvalid && bus.s_rready;
    assign rd_ok   = {1'b0, bus.s_araddr} < DEPTH_L;

    always_comb begin
        r_next       = r_state;
        bus.s_rvalid = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (ar_fire) r_next = R_DATA;
            end
            R_DATA: begin
                bus.s_rvalid = 1'b1;
                if (bus.s_rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Memory is read before any same-edge write lands, so a
    // colliding read sees the old contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= R_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            disp_seg <= {NUM_DIGITS{8'h03}};
        end else begin
            r_state <= r_next;
            if (ar_fire) begin
                rdata_q <= rd_ok ? mem[bus.s_araddr] : '0;
                rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
            if (r_fire && rresp_q == RESP_OKAY) begin
                for (int k = 0; k < NUM_DIGITS; k++)
                    disp_seg[8*k +: 8] <= seg7(rdata_q[4*k +: 4]);
            end
        end
    end

endmodule
